vga_text_fetch_arbiter: RTL and testbench

- Shares one single-port text RAM between the VGA display fetch path and a CPU write port.
- Watches the horizontal and vertical vga_axis counter outputs and issues one read per character cell, one cell ahead of display.
- The display path has absolute priority. The CPU gets every RAM cycle the display does not claim, through a valid/ready handshake.
- Sits between the two axis counters, the text RAM and the glyph/attribute pipeline.

---
 rtl/vga_text_fetch_arbiter.sv | 131 +++++++++++++
 tb/tb_vga_text_fetch_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_fetch_arbiter.sv
// Text RAM arbiter: display cell fetches have absolute priority. The CPU write
// port gets every RAM cycle the display does not claim.
module vga_text_fetch_arbiter #(
    parameter int COLUMNS     = 80,
    parameter int ROWS        = 30,
    parameter int PIXELS      = 10,
    parameter int FETCH_PIXEL = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = $clog2(COLUMNS*ROWS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        increment,
    input  logic                        h_carry,
    input  logic                        h_active,
    input  logic [$clog2(COLUMNS)-1:0]  h_block,
    input  logic [$clog2(PIXELS)-1:0]   h_pixel,
    input  logic                        v_active,
    input  logic [$clog2(ROWS)-1:0]     v_block,
    input  logic                        cpu_valid,
    output logic                        cpu_ready,
    input  logic [ADDR_WIDTH-1:0]       cpu_addr,
    input  logic [DATA_WIDTH-1:0]       cpu_data,
    output logic                        cpu_error,
    output logic                        ram_en,
    output logic                        ram_we,
    output logic [ADDR_WIDTH-1:0]       ram_addr,
    output logic [DATA_WIDTH-1:0]       ram_wdata,
    input  logic [DATA_WIDTH-1:0]       ram_rdata,
    output logic                        code_valid,
    output logic [DATA_WIDTH-1:0]       code
);
    localparam int HB_W = $clog2(COLUMNS);
    localparam int PX_W = $clog2(PIXELS);
    // One extra bit so the cell count itself is always representable.
    localparam logic [ADDR_WIDTH:0] CELLS = (ADDR_WIDTH+1)'(COLUMNS*ROWS);

    logic                  line_pending_reg;
    logic                  line_fetch;
    logic                  cell_fetch;
    logic                  disp_req;
    logic [ADDR_WIDTH-1:0] fetch_col;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  cpu_xfer;
    logic                  cpu_in_range;

    logic                  ram_en_reg;
    logic                  ram_we_reg;
    logic [ADDR_WIDTH-1:0] ram_addr_reg;
    logic [DATA_WIDTH-1:0] ram_wdata_reg;
    logic                  cpu_error_reg;
    logic                  rd_stage1_reg;
    logic                  rd_stage2_reg;
    logic                  code_valid_reg;
    logic [DATA_WIDTH-1:0] code_reg;

    // Column 0 is fetched one cycle after the line carry so the row counter
    // has already advanced; later cells are fetched one cell ahead of display.
    assign line_fetch = line_pending_reg && v_active;
    assign cell_fetch = increment && h_active && v_active
                        && (h_pixel == PX_W'(FETCH_PIXEL))
                        && (h_block != HB_W'(COLUMNS-1));
    assign disp_req   = line_fetch || cell_fetch;
    assign fetch_col  = line_fetch ? '0 : ADDR_WIDTH'(h_block) + ADDR_WIDTH'(1);
    assign fetch_addr = ADDR_WIDTH'(v_block) * ADDR_WIDTH'(COLUMNS) + fetch_col;

    // CPU gets any cycle the display leaves free.
    assign cpu_ready    = !reset && !disp_req;
    assign cpu_xfer     = cpu_valid && cpu_ready;
    assign cpu_in_range = {1'b0, cpu_addr} < CELLS;

    // Delay the horizontal carry by one cycle to form the line-start fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_pending_reg <= 1'b0;
        end else begin
            line_pending_reg <= h_carry;
        end
    end

    // Registered RAM port: display read wins, otherwise an in-range CPU write.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_en_reg    <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            cpu_error_reg <= 1'b0;
        end else begin
            cpu_error_reg <= cpu_xfer && !cpu_in_range;
            if (disp_req) begin
                ram_en_reg   <= 1'b1;
                ram_we_reg   <= 1'b0;
                ram_addr_reg <= fetch_addr;
            end else if (cpu_xfer && cpu_in_range) begin
                ram_en_reg    <= 1'b1;
                ram_we_reg    <= 1'b1;
                ram_addr_reg  <= cpu_addr;
                ram_wdata_reg <= cpu_data;
            end else begin
                ram_en_reg <= 1'b0;
                ram_we_reg <= 1'b0;
            end
        end
    end

    // Read return pipeline: track each fetch until its data arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_stage1_reg  <= 1'b0;
            rd_stage2_reg  <= 1'b0;
            code_valid_reg <= 1'b0;
            code_reg       <= '0;
        end else begin
            rd_stage1_reg  <= disp_req;
            rd_stage2_reg  <= rd_stage1_reg;
            code_valid_reg <= rd_stage2_reg;
            if (rd_stage2_reg) begin
                code_reg <= ram_rdata;
            end
        end
    end

    assign ram_en     = ram_en_reg;
    assign ram_we     = ram_we_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_wdata  = ram_wdata_reg;
    assign cpu_error  = cpu_error_reg;
    assign code_valid = code_valid_reg;
    assign code       = code_reg;
endmodule

// File: tb/tb_vga_text_fetch_arbiter.sv
// Scoreboard bench for vga_text_fetch_arbiter with a behavioural text RAM.
module tb_vga_text_fetch_arbiter;
    localparam int COLUMNS = 80;
    localparam int ROWS    = 30;
    localparam int CELLS   = COLUMNS*ROWS;
    localparam int AW      = 12;
    localparam int DW      = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          increment = 1'b0;
    logic          h_carry = 1'b0;
    logic          h_active = 1'b0;
    logic [6:0]    h_block = '0;
    logic [3:0]    h_pixel = '0;
    logic          v_active = 1'b0;
    logic [4:0]    v_block = '0;
    logic          cpu_valid = 1'b0;
    logic          cpu_ready;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_data = '0;
    logic          cpu_error;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          code_valid;
    logic [DW-1:0] code;

    vga_text_fetch_arbiter dut (
        .clk(clk), .reset(reset), .increment(increment), .h_carry(h_carry),
        .h_active(h_active), .h_block(h_block), .h_pixel(h_pixel),
        .v_active(v_active), .v_block(v_block), .cpu_valid(cpu_valid),
        .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_error(cpu_error), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .code_valid(code_valid), .code(code)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } acc_t;
    typedef struct { int cyc; logic [DW-1:0] word; } code_t;

    acc_t    acc_q[$];
    code_t   code_q[$];
    int      err_q[$];
    logic [DW-1:0] mem[CELLS];
    logic [DW-1:0] exp_mem[CELLS];
    int      cyc = 0;
    int      checks = 0;
    int      failures = 0;
    bit      lp_model = 1'b0;
    bit      prev_rst = 1'b0;
    acc_t    mon_acc;
    code_t   mon_code;
    int      mon_err;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM with one cycle read latency.
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        else if (ram_en) ram_rdata <= mem[ram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_zero();
        check_eq("rst_ram_en", ram_en, 0);
        check_eq("rst_ram_we", ram_we, 0);
        check_eq("rst_ram_addr", ram_addr, 0);
        check_eq("rst_ram_wdata", ram_wdata, 0);
        check_eq("rst_cpu_error", cpu_error, 0);
        check_eq("rst_code_valid", code_valid, 0);
        check_eq("rst_code", code, 0);
    endtask

    // One clock of stimulus; the bench's own model predicts RAM traffic.
    task automatic drive_cycle(input bit rst, input bit hc, input bit inc, input bit ha,
                               input bit va, input logic [3:0] hp, input logic [6:0] hb,
                               input logic [4:0] vb, input bit cv, input logic [AW-1:0] ca,
                               input logic [DW-1:0] cd, output bit accepted);
        int k;
        bit disp;
        bit exp_ready;
        int addr;
        @(posedge clk);
        #1;
        k = cyc;
        if (prev_rst) check_zero();
        reset = rst; h_carry = hc; increment = inc; h_active = ha; v_active = va;
        h_pixel = hp; h_block = hb; v_block = vb; cpu_valid = cv; cpu_addr = ca; cpu_data = cd;
        accepted = 1'b0;
        if (rst) begin
            exp_ready = 1'b0;
            for (int i = acc_q.size()-1; i >= 0; i--) if (acc_q[i].cyc > k) acc_q.delete(i);
            for (int i = code_q.size()-1; i >= 0; i--) if (code_q[i].cyc > k) code_q.delete(i);
            for (int i = err_q.size()-1; i >= 0; i--) if (err_q[i] > k) err_q.delete(i);
        end else begin
            disp = (lp_model && va) || (inc && ha && va && hp == 4'd2 && hb != 7'd79);
            exp_ready = !disp;
            if (disp) begin
                addr = int'(vb) * COLUMNS + ((lp_model && va) ? 0 : int'(hb) + 1);
                acc_q.push_back('{k+1, 1'b0, AW'(addr), '0});
                code_q.push_back('{k+3, exp_mem[addr]});
            end else if (cv) begin
                accepted = 1'b1;
                if (int'(ca) < CELLS) begin
                    acc_q.push_back('{k+1, 1'b1, ca, cd});
                    exp_mem[ca] = cd;
                end else begin
                    err_q.push_back(k+1);
                end
            end
        end
        #2;
        check_eq("cpu_ready", cpu_ready, exp_ready);
        lp_model = rst ? 1'b0 : hc;
        prev_rst = rst;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++)
            drive_cycle(0, 0, 0, 0, 0, 4'd0, 7'd0, 5'd0, 0, '0, '0, acc);
    endtask

    // Compare DUT outputs against the scoreboard every cycle.
    always @(negedge clk) begin
        if (ram_en) begin
            if (acc_q.size() == 0) check_eq("ram_unexpected", ram_en, 0);
            else begin
                mon_acc = acc_q.pop_front();
                check_eq("ram_cycle", cyc, mon_acc.cyc);
                check_eq("ram_we", ram_we, mon_acc.we);
                check_eq("ram_addr", ram_addr, mon_acc.addr);
                if (mon_acc.we) check_eq("ram_wdata", ram_wdata, mon_acc.data);
                $display("cyc %0d ram %s addr=%0d data=%h", cyc, ram_we ? "wr" : "rd", ram_addr, ram_wdata);
            end
        end else begin
            check_eq("ram_we_idle", ram_we, 0);
            if (acc_q.size() > 0 && acc_q[0].cyc <= cyc) begin
                check_eq("ram_missing", ram_en, 1);
                void'(acc_q.pop_front());
            end
        end
        if (code_valid) begin
            if (code_q.size() == 0) check_eq("code_unexpected", code_valid, 0);
            else begin
                mon_code = code_q.pop_front();
                check_eq("code_cycle", cyc, mon_code.cyc);
                check_eq("code", code, mon_code.word);
                $display("cyc %0d code %h", cyc, code);
            end
        end else if (code_q.size() > 0 && code_q[0].cyc <= cyc) begin
            check_eq("code_missing", code_valid, 1);
            void'(code_q.pop_front());
        end
        if (cpu_error) begin
            if (err_q.size() == 0) check_eq("err_unexpected", cpu_error, 0);
            else begin
                mon_err = err_q.pop_front();
                check_eq("err_cycle", cyc, mon_err);
                $display("cyc %0d cpu_error", cyc);
            end
        end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
            check_eq("err_missing", cpu_error, 1);
            void'(err_q.pop_front());
        end
    end

    initial begin
        bit acc;
        logic          cv;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        for (int i = 0; i < CELLS; i++) begin
            mem[i] = DW'(i * 3 + 16'h1000);
            exp_mem[i] = DW'(i * 3 + 16'h1000);
        end
        mem[240] = 16'hBEEF;
        exp_mem[240] = 16'hBEEF;

        // Reset held, then released.
        for (int i = 0; i < 5; i++)
            drive_cycle(1, 0, 0, 0, 0, 4'd0, 7'd0, 5'd0, 0, '0, '0, acc);
        idle(2);

        // Line start on row 3 fetches cell 240.
        drive_cycle(0, 1, 0, 0, 1, 4'd0, 7'd0, 5'd3, 0, '0, '0, acc);
        drive_cycle(0, 0, 0, 0, 1, 4'd0, 7'd0, 5'd3, 0, '0, '0, acc);
        idle(4);

        // Cell fetch one ahead; last column and other pixels do not fetch.
        drive_cycle(0, 0, 1, 1, 1, 4'd2, 7'd5, 5'd0, 0, '0, '0, acc);
        drive_cycle(0, 0, 1, 1, 1, 4'd2, 7'd79, 5'd0, 0, '0, '0, acc);
        drive_cycle(0, 0, 1, 1, 1, 4'd3, 7'd6, 5'd0, 0, '0, '0, acc);
        drive_cycle(0, 0, 0, 1, 1, 4'd2, 7'd7, 5'd0, 0, '0, '0, acc);
        idle(3);

        // CPU collides with a display fetch, then retries.
        drive_cycle(0, 0, 1, 1, 1, 4'd2, 7'd5, 5'd0, 1, 12'd100, 16'h1234, acc);
        drive_cycle(0, 0, 1, 1, 1, 4'd3, 7'd5, 5'd0, 1, 12'd100, 16'h1234, acc);
        // Back-to-back reads, then read back the written cell (row 1, col 20).
        drive_cycle(0, 0, 1, 1, 1, 4'd2, 7'd10, 5'd2, 0, '0, '0, acc);
        drive_cycle(0, 0, 1, 1, 1, 4'd2, 7'd11, 5'd29, 0, '0, '0, acc);
        drive_cycle(0, 0, 1, 1, 1, 4'd2, 7'd19, 5'd1, 0, '0, '0, acc);
        idle(4);

        // Out-of-range and last valid CPU addresses.
        drive_cycle(0, 0, 0, 0, 0, 4'd0, 7'd0, 5'd0, 1, 12'd2400, 16'hDEAD, acc);
        drive_cycle(0, 0, 0, 0, 0, 4'd0, 7'd0, 5'd0, 1, 12'd2399, 16'hCAFE, acc);
        // Inactive frame: the CPU owns a fetch-phase cycle.
        drive_cycle(0, 1, 1, 1, 0, 4'd2, 7'd3, 5'd4, 1, 12'd7, 16'h0707, acc);
        drive_cycle(0, 0, 1, 1, 0, 4'd2, 7'd3, 5'd4, 1, 12'd8, 16'h0808, acc);
        idle(3);

        // Reset one cycle after a fetch kills the read.
        drive_cycle(0, 0, 1, 1, 1, 4'd2, 7'd5, 5'd0, 0, '0, '0, acc);
        drive_cycle(1, 0, 0, 0, 0, 4'd0, 7'd0, 5'd0, 0, '0, '0, acc);
        idle(5);

        // Random traffic; CPU request held stable while stalled.
        cv = 1'b0; ca = '0; cd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!cv || acc) begin
                cv = ($urandom_range(0, 2) != 0);
                ca = AW'($urandom_range(0, 2450));
                cd = DW'($urandom);
            end
            drive_cycle(0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1) != 0,
                        $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                        4'($urandom_range(0, 9)), 7'($urandom_range(0, 79)),
                        5'($urandom_range(0, 29)), cv, ca, cd, acc);
        end
        idle(6);

        check_eq("acc_drain", acc_q.size(), 0);
        check_eq("code_drain", code_q.size(), 0);
        check_eq("err_drain", err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
